// File: rtl/lc3b_write_buffer_pkg.sv
// Shared types for the L1 eviction write buffer.
//   lc3b_wbuf_state : drain FSM state (idle between drains / write in flight)
//   line_ofs()      : number of byte-offset bits in a line of the given width
package lc3b_write_buffer_pkg;

  typedef enum logic {
    wbuf_idle,
    wbuf_write
  } lc3b_wbuf_state;

  function automatic int unsigned line_ofs(input int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/lc3b_write_buffer_if.sv
// Bus bundle for the eviction write buffer.
//   in_*     : eviction push from L1 (in_ready = not full)
//   lookup_* : L1 miss probe into buffered lines (combinational)
//   mem_*    : pmem-style drain handshake toward the next memory level
//   empty/count : occupancy status
// slave modport is the buffer's view, master is the L1/memory side.
interface lc3b_write_buffer_if #(
  parameter int unsigned LINE_W = 128,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              in_write;
  logic [ADDR_W-1:0] in_addr;
  logic [LINE_W-1:0] in_wdata;
  logic              in_ready;
  logic [ADDR_W-1:0] lookup_addr;
  logic              lookup_hit;
  logic [LINE_W-1:0] lookup_rdata;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_resp;
  logic              empty;
  logic [CW-1:0]     count;

  modport slave (
    input  in_write, in_addr, in_wdata, lookup_addr, mem_resp,
    output in_ready, lookup_hit, lookup_rdata, mem_write, mem_address, mem_wdata,
           empty, count
  );

  modport master (
    output in_write, in_addr, in_wdata, lookup_addr, mem_resp,
    input  in_ready, lookup_hit, lookup_rdata, mem_write, mem_address, mem_wdata,
           empty, count
  );

endinterface

// File: rtl/lc3b_write_buffer_match.sv
// Tag match with newest-first priority over the circular buffer.
//   valid : per-entry qualifier mask
//   tags  : per-entry line tags
//   probe : tag being searched for
//   tail  : next free slot; the slot just before it is the newest entry
//   hit   : some qualified entry matches
//   idx   : newest matching entry
module lc3b_wbuf_match #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned TAG_W = 12,
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  input  logic [TAG_W-1:0] tags [DEPTH],
  input  logic [TAG_W-1:0] probe,
  input  logic [PW-1:0]    tail,
  output logic             hit,
  output logic [PW-1:0]    idx
);

  logic [PW-1:0] slot;

  // Walk backwards from tail-1 (newest) to tail (oldest when full); the
  // pointer arithmetic wraps naturally because DEPTH is a power of 2.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    slot = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      slot = tail - PW'(k);
      if (!hit && valid[slot] && tags[slot] == probe) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/lc3b_write_buffer.sv
// Eviction write buffer between L1 D-cache and next memory level.
// Accepts dirty-line pushes in one cycle, coalesces writes to a buffered
// line, drains oldest-first over mem_*, and forwards buffered data to L1
// miss lookups.
//   clk, rst : clock, synchronous active-high reset
//   bus      : lc3b_write_buffer_if slave (push, lookup, drain, status)
module lc3b_write_buffer
  import lc3b_write_buffer_pkg::*;
#(
  parameter int unsigned LINE_W = 128,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  lc3b_write_buffer_if.slave  bus
);

  localparam int unsigned OFS   = line_ofs(LINE_W);
  localparam int unsigned TAG_W = ADDR_W - OFS;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [TAG_W-1:0]  tag_d  [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [LINE_W-1:0] data_d [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  lc3b_wbuf_state    state_q, state_d;
  logic              mem_write_q, mem_write_d;

  logic [TAG_W-1:0]  in_tag, look_tag;
  logic [DEPTH-1:0]  push_mask;
  logic              push_hit, look_hit;
  logic [PW-1:0]     push_idx, look_idx;
  logic              full, push, pop, append;

  assign in_tag   = bus.in_addr[ADDR_W-1:OFS];
  assign look_tag = bus.lookup_addr[ADDR_W-1:OFS];
  assign full     = (count_q == CW'(DEPTH));
  assign push     = bus.in_write && !full;
  assign pop      = (state_q == wbuf_write) && bus.mem_resp;
  assign append   = push && !push_hit;

  // The head is frozen while its write is in flight, so it is removed from
  // the coalesce candidates; a matching push then appends a newer copy.
  always_comb begin
    push_mask = valid_q;
    if (state_q == wbuf_write) push_mask[head_q] = 1'b0;
  end

  lc3b_wbuf_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_push_match (
    .valid (push_mask), .tags (tag_q), .probe (in_tag), .tail (tail_q),
    .hit   (push_hit),  .idx  (push_idx)
  );

  lc3b_wbuf_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_look_match (
    .valid (valid_q), .tags (tag_q), .probe (look_tag), .tail (tail_q),
    .hit   (look_hit), .idx (look_idx)
  );

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    state_d = state_q;

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end

    if (push) begin
      if (push_hit) begin
        data_d[push_idx] = bus.in_wdata;
      end else begin
        valid_d[tail_q] = 1'b1;
        tag_d[tail_q]   = in_tag;
        data_d[tail_q]  = bus.in_wdata;
        tail_d          = tail_q + PW'(1);
      end
    end

    count_d = count_q + CW'(append) - CW'(pop);

    // Uses the registered count so a push never starts a drain the same
    // cycle; this also gives the mandatory idle cycle between drains.
    case (state_q)
      wbuf_idle:  if (count_q != '0) state_d = wbuf_write;
      wbuf_write: if (pop)           state_d = wbuf_idle;
      default:                       state_d = wbuf_idle;
    endcase

    mem_write_d = (state_d == wbuf_write);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      state_q     <= wbuf_idle;
      mem_write_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      state_q     <= state_d;
      mem_write_q <= mem_write_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
    end
  end

  assign bus.in_ready     = !full;
  assign bus.empty        = (count_q == '0);
  assign bus.count        = count_q;
  assign bus.mem_write    = mem_write_q;
  assign bus.mem_address  = {tag_q[head_q], {OFS{1'b0}}};
  assign bus.mem_wdata    = data_q[head_q];
  assign bus.lookup_hit   = look_hit;
  assign bus.lookup_rdata = look_hit ? data_q[look_idx] : '0;

endmodule

// File: tb/tb_lc3b_write_buffer.sv
// Self-checking bench for lc3b_write_buffer: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_lc3b_write_buffer;

  localparam int unsigned LINE_W = 128;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned OFS    = 4;
  localparam int unsigned TAG_W  = ADDR_W - OFS;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lc3b_write_buffer_if #(.LINE_W(LINE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  lc3b_write_buffer #(.LINE_W(LINE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: oldest entry at index 0; busy = head write in flight.
  ent_t mq[$];
  bit   busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                          input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_lookup(input logic [TAG_W-1:0] t, output bit hit,
                              output logic [LINE_W-1:0] rd);
    hit = 1'b0;
    rd  = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!hit && mq[i].tag == t) begin
        hit = 1'b1;
        rd  = mq[i].data;
      end
    end
  endtask

  task automatic check_state();
    check_eq("count",    LINE_W'(bus.count),     LINE_W'(mq.size()));
    check_eq("empty",    LINE_W'(bus.empty),     LINE_W'(mq.size() == 0));
    check_eq("in_ready", LINE_W'(bus.in_ready),  LINE_W'(mq.size() != DEPTH));
    check_eq("mem_write", LINE_W'(bus.mem_write), LINE_W'(busy));
    if (busy) begin
      check_eq("mem_address", LINE_W'(bus.mem_address), LINE_W'({mq[0].tag, 4'h0}));
      check_eq("mem_wdata", bus.mem_wdata, mq[0].data);
    end
  endtask

  // One clock cycle: apply inputs, check lookup before the edge, advance the
  // model by the push/pop/drain rules, then check registered state.
  task automatic cyc(input bit r, input bit w, input logic [ADDR_W-1:0] a,
                     input logic [LINE_W-1:0] d, input bit resp,
                     input logic [ADDR_W-1:0] la);
    bit                exp_hit;
    logic [LINE_W-1:0] exp_rd;
    int                pre, tgt;
    bit                pop;
    rst             = r;
    bus.in_write    = w;
    bus.in_addr     = a;
    bus.in_wdata    = d;
    bus.mem_resp    = resp;
    bus.lookup_addr = la;
    #1;
    if (!r) begin
      model_lookup(la[ADDR_W-1:OFS], exp_hit, exp_rd);
      check_eq("lookup_hit",   LINE_W'(bus.lookup_hit), LINE_W'(exp_hit));
      check_eq("lookup_rdata", bus.lookup_rdata, exp_rd);
    end
    @(posedge clk);
    if (r) begin
      mq.delete();
      busy = 1'b0;
    end else begin
      pre = mq.size();
      pop = busy && resp;
      if (w && pre != DEPTH) begin
        tgt = -1;
        for (int i = pre - 1; i >= (busy ? 1 : 0); i--)
          if (tgt < 0 && mq[i].tag == a[ADDR_W-1:OFS]) tgt = i;
        if (tgt >= 0) mq[tgt].data = d;
        else          mq.push_back('{tag: a[ADDR_W-1:OFS], data: d});
      end
      if (pop) void'(mq.pop_front());
      busy = busy ? !pop : (pre != 0);
    end
    #1;
    check_state();
  endtask

  task automatic nop(input bit resp);
    cyc(1'b0, 1'b0, '0, '0, resp, 16'h0);
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
    cyc(1'b0, 1'b1, a, d, 1'b0, a);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, '0, '0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic wait_busy();
    for (int k = 0; k < 10 && !busy; k++) nop(1'b0);
    check_eq("busy_timeout", LINE_W'(busy), LINE_W'(1));
  endtask

  task automatic drain_all();
    for (int k = 0; k < 200 && mq.size() != 0; k++)
      cyc(1'b0, 1'b0, '0, '0, busy, 16'($urandom));
    check_eq("drain_timeout", LINE_W'(mq.size()), '0);
  endtask

  logic [LINE_W-1:0] d0, d1, d2, d3, d4;
  logic [TAG_W-1:0]  pool [6];
  logic [ADDR_W-1:0] ra, rla;

  initial begin
    bus.in_write = 1'b0; bus.in_addr = '0; bus.in_wdata = '0;
    bus.mem_resp = 1'b0; bus.lookup_addr = '0;
    busy = 1'b0;

    // Reset state
    do_reset();
    check_eq("rst_mem_write", LINE_W'(bus.mem_write), '0);
    check_eq("rst_empty",     LINE_W'(bus.empty),     LINE_W'(1));

    // 1: single push and delayed completion
    d0 = rnd_line();
    push(16'h1230, d0);
    check_eq("t1_count", LINE_W'(bus.count), LINE_W'(1));
    nop(1'b0);
    check_eq("t1_mem_write", LINE_W'(bus.mem_write), LINE_W'(1));
    check_eq("t1_mem_address", LINE_W'(bus.mem_address), LINE_W'(16'h1230));
    for (int k = 0; k < 4; k++) nop(1'b0);
    nop(1'b1);
    check_eq("t1_count_done", LINE_W'(bus.count), '0);
    check_eq("t1_empty", LINE_W'(bus.empty), LINE_W'(1));
    check_eq("t1_mem_write_done", LINE_W'(bus.mem_write), '0);

    // 2: fill, overflow ignored, FIFO drain order
    do_reset();
    for (int k = 0; k < 4; k++) push(16'h4000 + 16'(k * 16'h0110), rnd_line());
    check_eq("t2_in_ready", LINE_W'(bus.in_ready), '0);
    push(16'h5550, rnd_line());
    check_eq("t2_count", LINE_W'(bus.count), LINE_W'(4));
    drain_all();

    // 3: back-to-back coalesce, lookup by different offset
    do_reset();
    d1 = rnd_line(); d2 = rnd_line();
    push(16'h2040, d1);
    push(16'h2048, d2);
    check_eq("t3_count", LINE_W'(bus.count), LINE_W'(1));
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 16'h2044);
    check_eq("t3_lookup_hit", LINE_W'(bus.lookup_hit), LINE_W'(1));
    check_eq("t3_lookup_rdata", bus.lookup_rdata, d2);
    drain_all();

    // 4: matching push while head draining appends a newer copy
    do_reset();
    d3 = rnd_line(); d4 = rnd_line();
    push(16'h3000, d3);
    nop(1'b0);
    push(16'h3000, d4);
    check_eq("t4_count", LINE_W'(bus.count), LINE_W'(2));
    check_eq("t4_mem_wdata", bus.mem_wdata, d3);
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 16'h3008);
    check_eq("t4_lookup_rdata", bus.lookup_rdata, d4);
    nop(1'b1);
    wait_busy();
    check_eq("t4_second_drain", bus.mem_wdata, d4);
    drain_all();

    // 5: push while full rejected even with same-cycle pop
    do_reset();
    for (int k = 0; k < 4; k++) push(16'h6000 + 16'(k * 16'h0020), rnd_line());
    cyc(1'b0, 1'b1, 16'h7770, rnd_line(), 1'b1, 16'h7770);
    check_eq("t5_count", LINE_W'(bus.count), LINE_W'(3));
    drain_all();

    // 6: reset mid-drain, then a stale mem_resp
    do_reset();
    push(16'h8880, rnd_line());
    wait_busy();
    cyc(1'b1, 1'b0, '0, '0, 1'b0, '0);
    check_eq("t6_mem_write", LINE_W'(bus.mem_write), '0);
    check_eq("t6_count", LINE_W'(bus.count), '0);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 16'h8880);
    check_eq("t6_count_after_resp", LINE_W'(bus.count), '0);

    // Randomized traffic over a small set of lines to provoke coalescing
    for (int i = 0; i < 6; i++) pool[i] = TAG_W'($urandom);
    for (int n = 0; n < 800; n++) begin
      ra  = {pool[$urandom_range(0, 5)], 4'($urandom)};
      rla = {pool[$urandom_range(0, 5)], 4'($urandom)};
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, ra, rnd_line(),
          $urandom_range(0, 2) == 0, rla);
    end
    drain_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
